uart_tx_controller: RTL and testbench

//   Sequences the memory-mapped UART transmit path behind the load/store unit.

---
 rtl/uart_tx_controller.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// UART transmit controller: LSU byte writes enter a small FIFO and are serialised
// as 8N1 frames on tx_line, with sticky done/overflow flags for the interrupt path.
module uart_tx_controller #(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 434
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_select,
    input  logic                        byte_ready,
    input  logic [7:0]                  wr_data,
    input  logic                        irq_clr,
    output logic                        tx_line,
    output logic                        tx_busy,
    output logic                        tx_active,
    output logic                        fifo_empty,
    output logic                        tx_done_irq,
    output logic                        overflow,
    output logic [1:0]                  dbg_state_o,
    output logic [$clog2(FIFO_DEPTH):0] dbg_count_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_line_q, tx_line_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic full;
    logic empty;
    logic push_req;
    logic push;
    logic pop;
    logic done_set;
    logic bit_end;

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for a push that arrived while the FIFO was full.
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = uart_select & byte_ready;
    assign push     = push_req & ~full;
    assign bit_end  = (baud_q == BAUD_W'(BAUD_DIV - 1));

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        done_set = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line level is computed from the next state so it can be registered
    // without adding a cycle of latency relative to the FSM.
    always_comb begin
        tx_line_d = 1'b1;
        case (state_d)
            START:   tx_line_d = 1'b0;
            DATA:    tx_line_d = shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign done_d = done_set | (done_q & ~irq_clr);
    assign ovf_d  = (push_req & full) | (ovf_q & ~irq_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_line_q <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_line_q <= tx_line_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_line     = tx_line_q;
    assign tx_busy     = full;
    assign fifo_empty  = empty;
    assign tx_active   = (state_q != IDLE);
    assign tx_done_irq = done_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller with BAUD_DIV=4, FIFO_DEPTH=4; tx_line is
// captured cycle by cycle and compared against frames built from the byte queue.
module tb_uart_tx_controller;

    localparam int BD = 4;
    localparam int FD = 4;
    localparam int FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_select = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       irq_clr = 1'b0;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_active;
    logic       fifo_empty;
    logic       tx_done_irq;
    logic       overflow;
    logic [1:0] dbg_state;
    logic [2:0] dbg_count;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q [$];
    logic       got_tx [$];
    logic       got_act [$];
    logic       got_busy [$];
    logic       got_ovf [$];

    uart_tx_controller #(.FIFO_DEPTH(FD), .BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_select (uart_select),
        .byte_ready  (byte_ready),
        .wr_data     (wr_data),
        .irq_clr     (irq_clr),
        .tx_line     (tx_line),
        .tx_busy     (tx_busy),
        .tx_active   (tx_active),
        .fifo_empty  (fifo_empty),
        .tx_done_irq (tx_done_irq),
        .overflow    (overflow),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        got_tx.delete();
        got_act.delete();
        got_busy.delete();
        got_ovf.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            got_tx.push_back(tx_line);
            got_act.push_back(tx_active);
            got_busy.push_back(tx_busy);
            got_ovf.push_back(overflow);
        end
    endtask

    // Start bit in bit 0, data LSB first, stop bit in bit 9.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    function automatic logic [199:0] expected_line();
        logic [199:0] v;
        logic [9:0]   fb;
        v = '0;
        for (int k = 0; k < exp_q.size() * FRAME; k++) begin
            fb = frame_bits(exp_q[k / FRAME]);
            v[k] = fb[(k / BD) % 10];
        end
        return v;
    endfunction

    function automatic logic [199:0] got_line();
        logic [199:0] v;
        v = '0;
        foreach (got_tx[k]) v[k] = got_tx[k];
        return v;
    endfunction

    function automatic int inactive_cycles();
        int n;
        n = 0;
        foreach (got_act[k]) if (got_act[k] !== 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({tx_line, tx_busy, tx_active, fifo_empty, tx_done_irq, overflow} !== 6'b100100)
            $display("FAIL reset_outputs: got %b want 100100",
                     {tx_line, tx_busy, tx_active, fifo_empty, tx_done_irq, overflow});
        else passes++;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({tx_line, tx_active, dbg_state, dbg_count} !== 7'b1000000)
            $display("FAIL post_reset_idle: got %b want 1000000",
                     {tx_line, tx_active, dbg_state, dbg_count});
        else passes++;
    endtask

    task automatic test_single();
        logic [199:0] ev;
        logic [199:0] gv;
        exp_q = '{8'hA5};
        uart_select = 1'b1; byte_ready = 1'b1; wr_data = 8'hA5;
        tick();
        uart_select = 1'b0; byte_ready = 1'b0;
        checks++;
        if ({tx_line, fifo_empty, tx_active} !== 3'b100)
            $display("FAIL single_queued: got line/empty/active %b want 100",
                     {tx_line, fifo_empty, tx_active});
        else passes++;
        capture(FRAME);
        ev = expected_line();
        gv = got_line();
        checks++;
        if (gv !== ev) $display("FAIL single_frame: got %h want %h", gv, ev);
        else passes++;
        checks++;
        if (inactive_cycles() != 0)
            $display("FAIL single_active: got %0d inactive cycles want 0", inactive_cycles());
        else passes++;
        checks++;
        if (tx_done_irq !== 1'b0) $display("FAIL single_irq_early: got %b want 0", tx_done_irq);
        else passes++;
        tick();
        checks++;
        if ({tx_done_irq, fifo_empty, tx_active, tx_line} !== 4'b1101)
            $display("FAIL single_done: got irq/empty/active/line %b want 1101",
                     {tx_done_irq, fifo_empty, tx_active, tx_line});
        else passes++;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (tx_done_irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", tx_done_irq);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [199:0] ev;
        logic [199:0] gv;
        exp_q = '{8'h00, 8'hFF, 8'h55};
        uart_select = 1'b1; byte_ready = 1'b1; wr_data = 8'h00;
        tick();
        fork
            begin
                wr_data = 8'hFF;
                tick();
                wr_data = 8'h55;
                tick();
                uart_select = 1'b0; byte_ready = 1'b0;
            end
            capture(3 * FRAME);
        join
        ev = expected_line();
        gv = got_line();
        checks++;
        if (gv !== ev) $display("FAIL b2b_frames: got %h want %h", gv, ev);
        else passes++;
        checks++;
        if (inactive_cycles() != 0)
            $display("FAIL b2b_active: got %0d inactive cycles want 0", inactive_cycles());
        else passes++;
        tick();
        checks++;
        if ({tx_done_irq, tx_active} !== 2'b10)
            $display("FAIL b2b_done: got irq/active %b want 10", {tx_done_irq, tx_active});
        else passes++;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic test_overflow();
        logic [199:0] ev;
        logic [199:0] gv;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        uart_select = 1'b1; byte_ready = 1'b1; wr_data = 8'h11;
        tick();
        fork
            begin
                wr_data = 8'h22; tick();
                wr_data = 8'h33; tick();
                wr_data = 8'h44; tick();
                wr_data = 8'h55; tick();
                wr_data = 8'h66; tick();
                uart_select = 1'b0; byte_ready = 1'b0;
            end
            capture(5 * FRAME);
        join
        checks++;
        if ({got_busy[3], got_busy[4]} !== 2'b11)
            $display("FAIL ovf_busy: got %b want 11", {got_busy[3], got_busy[4]});
        else passes++;
        checks++;
        if ({got_ovf[3], got_ovf[4]} !== 2'b01)
            $display("FAIL ovf_flag: got %b want 01", {got_ovf[3], got_ovf[4]});
        else passes++;
        ev = expected_line();
        gv = got_line();
        checks++;
        if (gv !== ev) $display("FAIL ovf_frames: got %h want %h", gv, ev);
        else passes++;
        tick();
        checks++;
        if ({tx_done_irq, overflow, fifo_empty} !== 3'b111)
            $display("FAIL ovf_drained: got irq/ovf/empty %b want 111",
                     {tx_done_irq, overflow, fifo_empty});
        else passes++;
        exp_q.delete();
        capture(12);
        gv = got_line();
        checks++;
        if (gv[11:0] !== 12'hFFF || inactive_cycles() != 12)
            $display("FAIL ovf_no_sixth: got line %h inactive %0d want fff 12",
                     gv[11:0], inactive_cycles());
        else passes++;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if ({tx_done_irq, overflow} !== 2'b00)
            $display("FAIL ovf_clear: got %b want 00", {tx_done_irq, overflow});
        else passes++;
    endtask

    task automatic test_full_pop();
        logic [7:0] bytes [5];
        int waited;
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        uart_select = 1'b1; byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = bytes[i];
            tick();
        end
        uart_select = 1'b0; byte_ready = 1'b0;
        for (int i = 0; i < 36; i++) tick();
        checks++;
        if ({dbg_count, overflow, dbg_state} !== {3'd4, 1'b0, 2'd3})
            $display("FAIL fullpop_pre: got count/ovf/state %b want 100011",
                     {dbg_count, overflow, dbg_state});
        else passes++;
        uart_select = 1'b1; byte_ready = 1'b1; wr_data = 8'h99;
        tick();
        uart_select = 1'b0; byte_ready = 1'b0;
        checks++;
        if ({dbg_count, overflow, tx_busy, dbg_state} !== {3'd3, 1'b1, 1'b0, 2'd1})
            $display("FAIL fullpop_drop: got count/ovf/busy/state %b want 0111001",
                     {dbg_count, overflow, tx_busy, dbg_state});
        else passes++;
        waited = 0;
        while (tx_done_irq !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        checks++;
        if (tx_done_irq !== 1'b1 || waited != 4 * FRAME)
            $display("FAIL fullpop_drain: got irq %b after %0d cycles want 1 after %0d",
                     tx_done_irq, waited, 4 * FRAME);
        else passes++;
    endtask

    task automatic test_reset_mid();
        uart_select = 1'b1; byte_ready = 1'b1; wr_data = 8'h3C;
        tick();
        wr_data = 8'h81;
        tick();
        uart_select = 1'b0; byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if ({dbg_state, tx_line, fifo_empty, tx_done_irq, overflow} !== {2'd2, 1'b1, 1'b0, 1'b1, 1'b1})
            $display("FAIL mid_pre: got state/line/empty/irq/ovf %b want 101011",
                     {dbg_state, tx_line, fifo_empty, tx_done_irq, overflow});
        else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_line, tx_busy, tx_active, fifo_empty, tx_done_irq, overflow, dbg_state, dbg_count}
            !== 11'b100100_00_000)
            $display("FAIL mid_reset: got %b want 10010000000",
                     {tx_line, tx_busy, tx_active, fifo_empty, tx_done_irq, overflow,
                      dbg_state, dbg_count});
        else passes++;
        tick();
        rst_n = 1'b1;
        capture(12);
        checks++;
        if (got_line() !== 200'hFFF || inactive_cycles() != 12)
            $display("FAIL mid_after: got line %h inactive %0d want fff 12",
                     got_line(), inactive_cycles());
        else passes++;
    endtask

    task automatic test_irq_stop_edge();
        uart_select = 1'b1; byte_ready = 1'b1; wr_data = 8'h0F;
        tick();
        uart_select = 1'b0; byte_ready = 1'b0;
        for (int i = 0; i < FRAME; i++) tick();
        checks++;
        if ({tx_done_irq, dbg_state} !== {1'b0, 2'd3})
            $display("FAIL edge_pre: got irq/state %b want 011", {tx_done_irq, dbg_state});
        else passes++;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if ({tx_done_irq, tx_active} !== 2'b10)
            $display("FAIL edge_set_wins: got irq/active %b want 10", {tx_done_irq, tx_active});
        else passes++;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (tx_done_irq !== 1'b0) $display("FAIL edge_clear: got %b want 0", tx_done_irq);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_irq_stop_edge();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
